phase_sequence_monitor: RTL

- Synthesizable, parametrised monitor bound alongside the intersection controller. Watches NUM_CH green outputs.
- Counts green-to-green handovers per ordered channel pair and tracks which required handovers have occurred.
- Flags conflicting greens, starved channels and too-short green phases.
- Carries the simulation/formal cover intent into silicon-observable counters and sticky flags for NUM_CH channels.

---
 rtl/phase_sequence_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/phase_sequence_monitor.sv
// Watches NUM_CH controller greens: per-pair handover counters, required-handover coverage,
// and sticky conflict / starvation / short-green flags. All outputs registered; clear is synchronous.
module phase_sequence_monitor #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int STARVE_LIMIT = 64,
  parameter int MIN_GREEN    = 4,
  parameter logic [NUM_CH*NUM_CH-1:0] CONFLICT_MASK = 16'h08C0,
  parameter logic [NUM_CH*NUM_CH-1:0] REQ_MASK      = '1,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] green,
  input  logic              clear,
  input  logic [SEL_W-1:0]  sel_from,
  input  logic [SEL_W-1:0]  sel_to,
  output logic [CNT_W-1:0]  pair_count,
  output logic [NUM_CH-1:0] conflict_vec,
  output logic              conflict,
  output logic [NUM_CH-1:0] starve,
  output logic [NUM_CH-1:0] short_green,
  output logic              covered_all
);

  localparam int WAIT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int DWELL_W = (MIN_GREEN > 0) ? $clog2(MIN_GREEN + 1) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_GREEN);

  logic [NUM_CH-1:0]        green_q, rise, fall;
  logic [SEL_W-1:0]         last_fall, last_fall_nxt;
  logic                     last_fall_valid, last_fall_valid_nxt;
  logic [CNT_W-1:0]         pair_cnt     [NUM_CH][NUM_CH];
  logic [CNT_W-1:0]         pair_cnt_nxt [NUM_CH][NUM_CH];
  logic [NUM_CH*NUM_CH-1:0] seen, seen_nxt, req_eff;
  logic [WAIT_W-1:0]        wait_cnt  [NUM_CH];
  logic [WAIT_W-1:0]        wait_nxt  [NUM_CH];
  logic [DWELL_W-1:0]       dwell_cnt [NUM_CH];
  logic [DWELL_W-1:0]       dwell_nxt [NUM_CH];
  logic [NUM_CH-1:0]        conflict_nxt, starve_nxt, short_nxt;
  logic                     covered_nxt;
  logic [CNT_W-1:0]         pair_sel;

  always_comb begin
    rise = green & ~green_q;
    fall = ~green & green_q;

    // Descending scan so the lowest falling index wins.
    last_fall_valid_nxt = last_fall_valid;
    last_fall_nxt       = last_fall;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fall[i]) begin
        last_fall_valid_nxt = 1'b1;
        last_fall_nxt       = SEL_W'(i);
      end
    end

    seen_nxt     = seen;
    conflict_nxt = conflict_vec;
    starve_nxt   = starve;
    short_nxt    = short_green;
    req_eff      = REQ_MASK;
    for (int i = 0; i < NUM_CH; i++) begin
      req_eff[i*NUM_CH+i] = 1'b0;
      for (int j = 0; j < NUM_CH; j++) begin
        pair_cnt_nxt[i][j] = pair_cnt[i][j];
        // Uses the registered last_fall, so a same-cycle fall only affects later rises.
        if (i != j && rise[j] && last_fall_valid && last_fall == SEL_W'(i)) begin
          if (pair_cnt[i][j] != CNT_MAX)
            pair_cnt_nxt[i][j] = pair_cnt[i][j] + 1'b1;
          seen_nxt[i*NUM_CH+j] = 1'b1;
        end
        if (i != j && green[i] && green[j] &&
            (CONFLICT_MASK[i*NUM_CH+j] || CONFLICT_MASK[j*NUM_CH+i]))
          conflict_nxt[i] = 1'b1;
      end

      if (green[i])
        wait_nxt[i] = '0;
      else if (wait_cnt[i] != WAIT_MAX)
        wait_nxt[i] = wait_cnt[i] + 1'b1;
      else
        wait_nxt[i] = wait_cnt[i];
      if (wait_nxt[i] == WAIT_MAX)
        starve_nxt[i] = 1'b1;

      if (fall[i]) begin
        if (dwell_cnt[i] < DWELL_MAX)
          short_nxt[i] = 1'b1;
        dwell_nxt[i] = '0;
      end else if (green[i] && dwell_cnt[i] != DWELL_MAX) begin
        dwell_nxt[i] = dwell_cnt[i] + 1'b1;
      end else begin
        dwell_nxt[i] = dwell_cnt[i];
      end
    end

    if (clear) begin
      last_fall_valid_nxt = 1'b0;
      seen_nxt            = '0;
      conflict_nxt        = '0;
      starve_nxt          = '0;
      short_nxt           = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wait_nxt[i]  = '0;
        dwell_nxt[i] = '0;
        for (int j = 0; j < NUM_CH; j++)
          pair_cnt_nxt[i][j] = '0;
      end
    end

    covered_nxt = ((seen_nxt & req_eff) == req_eff);

    pair_sel = '0;
    if (sel_from != sel_to && int'(sel_from) < NUM_CH && int'(sel_to) < NUM_CH)
      pair_sel = pair_cnt[sel_from][sel_to];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      green_q         <= '0;
      last_fall       <= '0;
      last_fall_valid <= 1'b0;
      seen            <= '0;
      conflict_vec    <= '0;
      conflict        <= 1'b0;
      starve          <= '0;
      short_green     <= '0;
      covered_all     <= 1'b0;
      pair_count      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wait_cnt[i]  <= '0;
        dwell_cnt[i] <= '0;
        for (int j = 0; j < NUM_CH; j++)
          pair_cnt[i][j] <= '0;
      end
    end else begin
      green_q         <= green;
      last_fall       <= last_fall_nxt;
      last_fall_valid <= last_fall_valid_nxt;
      seen            <= seen_nxt;
      conflict_vec    <= conflict_nxt;
      conflict        <= |conflict_nxt;
      starve          <= starve_nxt;
      short_green     <= short_nxt;
      covered_all     <= covered_nxt;
      pair_count      <= pair_sel;
      for (int i = 0; i < NUM_CH; i++) begin
        wait_cnt[i]  <= wait_nxt[i];
        dwell_cnt[i] <= dwell_nxt[i];
        for (int j = 0; j < NUM_CH; j++)
          pair_cnt[i][j] <= pair_cnt_nxt[i][j];
      end
    end
  end

endmodule
